// File: rtl/ff_delay_line_pkg.sv
// Shared types and helpers for the ff_delay_line word delay line.
// Mode encoding and tap-select width calculation.
package ff_pkg;

  typedef enum logic [1:0] {
    FF_HOLD  = 2'b00,
    FF_SHIFT = 2'b01,
    FF_SSET  = 2'b10,
    FF_SCLR  = 2'b11
  } ff_mode_e;

  function automatic int ff_tw(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ff_delay_line_if.sv
// Control/data bundle between a user and the ff_delay_line.
// The user side is master; the delay line is slave.
interface ff_delay_line_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  import ff_pkg::*;

  localparam int TW = ff_tw(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);

  logic             En;
  ff_mode_e         Mode;
  logic [WIDTH-1:0] D;
  logic [TW-1:0]    TapSel;
  logic [WIDTH-1:0] Q;
  logic             QValid;
  logic [WIDTH-1:0] Tap;
  logic             TapValid;
  logic [FW-1:0]    Fill;
  logic             Full;

  modport master (
    output En, Mode, D, TapSel,
    input  Q, QValid, Tap, TapValid, Fill, Full
  );

  modport slave (
    input  En, Mode, D, TapSel,
    output Q, QValid, Tap, TapValid, Fill, Full
  );

endinterface

// File: rtl/ff_delay_line_word.sv
// One delay-line stage: a word register plus its valid flag.
// Clear wins over set, set wins over load, all gated by enable.
module ff_word #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] SET_VALUE = '1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sset_i,
  input  logic             sclr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] q_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;

  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    if (en_i) begin
      unique case (1'b1)
        sclr_i: begin
          word_d  = '0;
          valid_d = 1'b0;
        end
        sset_i: begin
          word_d  = SET_VALUE;
          valid_d = 1'b1;
        end
        load_i: begin
          word_d  = d_i;
          valid_d = valid_i;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign q_o     = word_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/ff_delay_line.sv
// WIDTH x DEPTH word delay line with valid tracking,
// a saturating fill counter and a combinational tap read-out.
module ff_delay_line
  import ff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] SET_VALUE = '1
) (
  input  logic           Clock,
  input  logic           Resetn,
  ff_delay_line_if.slave bus
);

  localparam int            FW       = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FULL_CNT = FW'(DEPTH);

  logic [WIDTH-1:0] word_w [DEPTH];
  logic             vld_w  [DEPTH];
  logic             sset, sclr, load;
  logic [FW-1:0]    fill_q, fill_d;
  logic [WIDTH-1:0] tap;
  logic             tap_v;

  always_comb begin
    sset = 1'b0;
    sclr = 1'b0;
    load = 1'b0;
    unique case (bus.Mode)
      FF_SHIFT: load = 1'b1;
      FF_SSET:  sset = 1'b1;
      FF_SCLR:  sclr = 1'b1;
      default:  ;
    endcase
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] din;
    logic             vin;
    if (k == 0) begin : g_head
      assign din = bus.D;
      assign vin = 1'b1;
    end else begin : g_body
      assign din = word_w[k-1];
      assign vin = vld_w[k-1];
    end
    ff_word #(
      .WIDTH     (WIDTH),
      .SET_VALUE (SET_VALUE)
    ) u_word (
      .clk_i   (Clock),
      .rst_ni  (Resetn),
      .en_i    (bus.En),
      .sset_i  (sset),
      .sclr_i  (sclr),
      .load_i  (load),
      .d_i     (din),
      .valid_i (vin),
      .q_o     (word_w[k]),
      .valid_o (vld_w[k])
    );
  end

  // Fill tracks popcount(valid) without summing the valid bits
  always_comb begin
    fill_d = fill_q;
    if (bus.En) begin
      unique case (bus.Mode)
        FF_SHIFT: begin
          if (fill_q != FULL_CNT) fill_d = fill_q + FW'(1);
        end
        FF_SSET: fill_d = FULL_CNT;
        FF_SCLR: fill_d = '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) fill_q <= '0;
    else         fill_q <= fill_d;
  end

  always_comb begin
    tap   = '0;
    tap_v = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (int'(bus.TapSel) == k) begin
        tap   = word_w[k];
        tap_v = vld_w[k];
      end
    end
  end

  assign bus.Q        = word_w[DEPTH-1];
  assign bus.QValid   = vld_w[DEPTH-1];
  assign bus.Tap      = tap;
  assign bus.TapValid = tap_v;
  assign bus.Fill     = fill_q;
  assign bus.Full     = (fill_q == FULL_CNT);

endmodule

// File: tb/tb_ff_delay_line.sv
// Bench for ff_delay_line: directed vector table, random run
// against a queue model, plus DEPTH=3 and DEPTH=1 builds.
module tb_ff_delay_line;
  import ff_pkg::*;

  logic Clock = 1'b0;
  logic Resetn;
  int   checks = 0;
  int   errors = 0;

  always #5 Clock = ~Clock;

  ff_delay_line_if #(.WIDTH(8), .DEPTH(4)) m  ();
  ff_delay_line_if #(.WIDTH(8), .DEPTH(3)) i3 ();
  ff_delay_line_if #(.WIDTH(8), .DEPTH(1)) i1 ();

  ff_delay_line #(.WIDTH(8), .DEPTH(4)) dut (
    .Clock (Clock), .Resetn (Resetn), .bus (m)
  );
  ff_delay_line #(.WIDTH(8), .DEPTH(3)) dut3 (
    .Clock (Clock), .Resetn (Resetn), .bus (i3)
  );
  ff_delay_line #(.WIDTH(8), .DEPTH(1)) dut1 (
    .Clock (Clock), .Resetn (Resetn), .bus (i1)
  );

  typedef struct {
    logic       rst;
    logic       en;
    ff_mode_e   mode;
    logic [7:0] d;
    logic [1:0] sel;
    logic [7:0] eq;
    logic       eqv;
    logic [2:0] efill;
    logic       efull;
    logic [7:0] etap;
    logic       etv;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic en,
                     input ff_mode_e mode, input logic [7:0] d,
                     input logic [1:0] sel, input logic [7:0] eq,
                     input logic eqv, input logic [2:0] efill,
                     input logic efull, input logic [7:0] etap,
                     input logic etv);
    vec_t v;
    v.rst = rst; v.en = en; v.mode = mode; v.d = d;
    v.sel = sel; v.eq = eq; v.eqv = eqv; v.efill = efill;
    v.efull = efull; v.etap = etap; v.etv = etv;
    vt.push_back(v);
  endtask

  // Model: queue of valid words, newest first; invalid stages read 0
  logic [7:0] mq[$];

  function automatic logic [7:0] mstage(input int k);
    return (k < mq.size()) ? mq[k] : 8'h00;
  endfunction

  task automatic mupdate(input logic rst, input logic en,
                         input ff_mode_e mode, input logic [7:0] d);
    if (!rst) mq.delete();
    else if (en) begin
      case (mode)
        FF_SHIFT: begin
          mq.push_front(d);
          if (mq.size() > 4) void'(mq.pop_back());
        end
        FF_SSET: begin
          mq.delete();
          repeat (4) mq.push_back(8'hFF);
        end
        FF_SCLR: mq.delete();
        default: ;
      endcase
    end
  endtask

  initial begin
    logic       r_rst, r_en;
    ff_mode_e   r_mode;
    logic [7:0] r_d;
    logic [1:0] r_sel;

    Resetn = 1'b0;
    m.En = 1'b0;  m.Mode = FF_HOLD;  m.D = '0;  m.TapSel = '0;
    i3.En = 1'b0; i3.Mode = FF_HOLD; i3.D = '0; i3.TapSel = '0;
    i1.En = 1'b0; i1.Mode = FF_HOLD; i1.D = '0; i1.TapSel = '0;

    // rst en mode d sel | q qv fill full tap tv
    add(0, 1, FF_SHIFT, 8'h99, 0, 8'h00, 0, 0, 0, 8'h00, 0);
    add(0, 0, FF_HOLD,  8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 0);
    add(1, 1, FF_SHIFT, 8'h11, 0, 8'h00, 0, 1, 0, 8'h11, 1);
    add(1, 1, FF_SHIFT, 8'h22, 1, 8'h00, 0, 2, 0, 8'h11, 1);
    add(1, 1, FF_SHIFT, 8'h33, 2, 8'h00, 0, 3, 0, 8'h11, 1);
    add(1, 1, FF_SHIFT, 8'h44, 3, 8'h11, 1, 4, 1, 8'h11, 1);
    add(1, 1, FF_HOLD,  8'h77, 0, 8'h11, 1, 4, 1, 8'h44, 1);
    add(1, 1, FF_HOLD,  8'h77, 1, 8'h11, 1, 4, 1, 8'h33, 1);
    add(1, 1, FF_HOLD,  8'h77, 2, 8'h11, 1, 4, 1, 8'h22, 1);
    add(1, 1, FF_HOLD,  8'h77, 3, 8'h11, 1, 4, 1, 8'h11, 1);
    add(1, 1, FF_SHIFT, 8'h55, 0, 8'h22, 1, 4, 1, 8'h55, 1);
    add(1, 1, FF_SHIFT, 8'h66, 0, 8'h33, 1, 4, 1, 8'h66, 1);
    add(1, 0, FF_HOLD,  8'h00, 1, 8'h33, 1, 4, 1, 8'h55, 1);
    add(1, 0, FF_HOLD,  8'h00, 2, 8'h33, 1, 4, 1, 8'h44, 1);
    add(1, 0, FF_HOLD,  8'h00, 3, 8'h33, 1, 4, 1, 8'h33, 1);
    add(1, 1, FF_SSET,  8'h00, 1, 8'hFF, 1, 4, 1, 8'hFF, 1);
    add(1, 1, FF_SCLR,  8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 0);
    add(1, 1, FF_SHIFT, 8'h11, 0, 8'h00, 0, 1, 0, 8'h11, 1);
    add(1, 0, FF_SHIFT, 8'hFF, 0, 8'h00, 0, 1, 0, 8'h11, 1);
    add(1, 0, FF_SHIFT, 8'hFF, 0, 8'h00, 0, 1, 0, 8'h11, 1);
    add(1, 0, FF_SHIFT, 8'hFF, 1, 8'h00, 0, 1, 0, 8'h00, 0);
    add(1, 1, FF_SHIFT, 8'h22, 0, 8'h00, 0, 2, 0, 8'h22, 1);
    add(1, 1, FF_SHIFT, 8'h33, 0, 8'h00, 0, 3, 0, 8'h33, 1);
    add(1, 1, FF_SHIFT, 8'h44, 3, 8'h11, 1, 4, 1, 8'h11, 1);
    add(0, 1, FF_SHIFT, 8'hAA, 0, 8'h00, 0, 0, 0, 8'h00, 0);

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge Clock);
      Resetn   = vt[i].rst;
      m.En     = vt[i].en;
      m.Mode   = vt[i].mode;
      m.D      = vt[i].d;
      m.TapSel = vt[i].sel;
      @(posedge Clock);
      #1;
      chk($sformatf("vec%0d.Q", i),        m.Q,        vt[i].eq);
      chk($sformatf("vec%0d.QValid", i),   m.QValid,   vt[i].eqv);
      chk($sformatf("vec%0d.Fill", i),     m.Fill,     vt[i].efill);
      chk($sformatf("vec%0d.Full", i),     m.Full,     vt[i].efull);
      chk($sformatf("vec%0d.Tap", i),      m.Tap,      vt[i].etap);
      chk($sformatf("vec%0d.TapValid", i), m.TapValid, vt[i].etv);
    end

    mq.delete();
    for (int i = 0; i < 400; i++) begin
      r_rst  = ($urandom_range(0, 31) != 0);
      r_en   = ($urandom_range(0, 3) != 0);
      r_mode = ff_mode_e'($urandom_range(0, 15) < 10 ? 1 :
                          $urandom_range(0, 3));
      r_d    = 8'($urandom);
      r_sel  = 2'($urandom);
      @(negedge Clock);
      Resetn   = r_rst;
      m.En     = r_en;
      m.Mode   = r_mode;
      m.D      = r_d;
      m.TapSel = r_sel;
      @(posedge Clock);
      mupdate(r_rst, r_en, r_mode, r_d);
      #1;
      chk("rnd.Q",        m.Q,        mstage(3));
      chk("rnd.QValid",   m.QValid,   mq.size() == 4);
      chk("rnd.Fill",     m.Fill,     mq.size());
      chk("rnd.Full",     m.Full,     mq.size() == 4);
      chk("rnd.Tap",      m.Tap,      mstage(int'(r_sel)));
      chk("rnd.TapValid", m.TapValid, int'(r_sel) < mq.size());
    end

    // Small builds: DEPTH=3 out-of-range tap and DEPTH=1 single stage
    @(negedge Clock);
    Resetn = 1'b0;
    m.En = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    i3.En = 1'b1; i3.Mode = FF_SHIFT; i3.TapSel = 2'd3;
    i1.En = 1'b1; i1.Mode = FF_SHIFT; i1.D = 8'h5A; i1.TapSel = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i3.D = 8'(8'hA1 + k);
      @(posedge Clock);
      #1;
      if (k == 0) begin
        @(negedge Clock);
        i1.En = 1'b0;
        chk("d1.Q",      i1.Q,        8'h5A);
        chk("d1.QValid", i1.QValid,   1'b1);
        chk("d1.Fill",   i1.Fill,     1'b1);
        chk("d1.Full",   i1.Full,     1'b1);
        chk("d1.Tap",    i1.Tap,      8'h5A);
      end else begin
        @(negedge Clock);
      end
    end
    i3.En = 1'b0;
    #1;
    chk("d3.Q",        i3.Q,        8'hA1);
    chk("d3.Full",     i3.Full,     1'b1);
    chk("d3.Fill",     i3.Fill,     2'd3);
    chk("d3.Tap3",     i3.Tap,      8'h00);
    chk("d3.TapValid3", i3.TapValid, 1'b0);
    i3.TapSel = 2'd0;
    #1;
    chk("d3.Tap0",     i3.Tap,      8'hA3);
    chk("d3.TapValid0", i3.TapValid, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ff_delay_line.md
Name: ff_delay_line

Overview:
- Parametrised successor to the single-bit flip-flop wrapper: a WIDTH-bit, DEPTH-stage register chain (word-serial shift register / delay line).
- Adds the following per stage: clock enable, synchronous set/clear modes, valid tracking, a fill counter and a tap read-out.
- Used wherever the design needs a fixed-latency delay of a data word, or a short history window of recent samples.

Parameters:
- WIDTH, 8, bits per word/stage (>=1)
- DEPTH, 4, number of stages (>=1); latency from D to Q in shift cycles
- SET_VALUE, {WIDTH{1'b1}}, word loaded into every stage by SSET mode

Ports:
- Clock  in  1  rising-edge clock
- Resetn  in  1  reset; one clock; reset is synchronous and active-low
- En  in  1  clock enable; gates all modes except reset
- Mode  in  2  00 HOLD, 01 SHIFT, 10 SSET, 11 SCLR
- D  in  WIDTH  word shifted into stage 0
- TapSel  in  TW  tap index, TW = max(1, $clog2(DEPTH))
- Q  out  WIDTH  stage DEPTH-1 contents
- QValid  out  1  valid flag of stage DEPTH-1
- Tap  out  WIDTH  contents of stage TapSel (combinational mux of registers)
- TapValid  out  1  valid flag of stage TapSel
- Fill  out  $clog2(DEPTH+1)  number of valid stages
- Full  out  1  Fill == DEPTH

Behaviour:
- State: stage[0..DEPTH-1] (WIDTH bits each), valid[0..DEPTH-1], Fill register.
- Reset: at a rising edge with Resetn=0, all stages become 0, all valid bits 0 and Fill 0. Therefore Q=0, QValid=0, Full=0.
- Reset overrides En and Mode.
- Reset asserted mid-stream discards all contents in that same edge; no partial shift occurs.
- Priority per edge: Resetn=0 > En=0 (hold everything) > Mode decode.
- HOLD (00): no change.
- SHIFT (01):
  - stage[0]<=D, valid[0]<=1.
  - stage[k]<=stage[k-1] and valid[k]<=valid[k-1] for k=1..DEPTH-1.
  - The old stage[DEPTH-1] is discarded.
  - Fill <= Fill+1, saturating at DEPTH. Once full, it stays at DEPTH on further shifts.
- SSET (10): all stages <= SET_VALUE, all valid <= 1, Fill <= DEPTH.
- SCLR (11): all stages <= 0, all valid <= 0, Fill <= 0. This is identical to reset but requires En=1.
- Latency:
  - A word shifted in at edge n appears on Q after edge n+DEPTH-1 (DEPTH shift edges total, counting its own).
  - Non-shift cycles (HOLD or En=0) in between stretch the latency; no data is lost.
- Outputs:
  - Q, QValid and Fill are direct register outputs with no extra pipeline stage.
  - Tap and TapValid are combinational from TapSel.
  - TapSel >= DEPTH (possible when DEPTH is not a power of 2) gives Tap=0, TapValid=0.
- DEPTH=1: single register. TapSel is 1 bit and only value 0 is legal; Fill is 1 bit.
- Fill always equals the popcount of valid[]. Valid bits are always a contiguous run starting at stage 0.

Decomposition:
- Shared package ff_pkg:
  - enum ff_mode_e {FF_HOLD=2'b00, FF_SHIFT=2'b01, FF_SSET=2'b10, FF_SCLR=2'b11}.
  - Function computing TW.
- Sub-module ff_word (WIDTH, SET_VALUE): one stage register plus its valid bit with En/sset/sclr/load. It is the generalised single flip-flop, instantiated DEPTH times in a generate loop.
- Top level holds the Fill counter and the tap mux.

Test Plan (WIDTH=8, DEPTH=4):
- Hold Resetn=0 for 2 edges, then release -> Q=00, QValid=0, Fill=0, Full=0.
- SHIFT with D=11,22,33,44 on 4 consecutive edges -> Q=11 and QValid=1 after the 4th edge; Fill=4, Full=1. Then TapSel=0..3 gives Tap=44,33,22,11.
- Shift 11, then En=0 for 3 cycles with Mode=SHIFT, D=FF -> state unchanged (Fill=1, Tap[0]=11). Resume with 22,33,44 -> Q=11 on the 4th shift edge.
- Full, then 2 more shifts of 55,66 -> Fill stays 4, Q=33; stages hold 66,55,44,33.
- Mode=SSET with En=1 -> all taps FF, Fill=4, QValid=1. Next edge Mode=SCLR -> all 00, Fill=0. Then Resetn=0 together with Mode=SHIFT, D=AA -> all 00 and stage 0 is not loaded.
- DEPTH=3 build: TapSel=3 -> Tap=00, TapValid=0. DEPTH=1 build: one SHIFT of 5A -> Q=5A, Full=1.
